// File: rtl/change_dispenser.sv
// Coin-return payout engine: latches a balance on request and pays it out greedily,
// one coin per cycle, from per-denomination stock that is replenished by inserted coins and refills.
module change_dispenser #(
  parameter int kNumCoins  = 3,
  parameter int BAL_W      = 32,
  parameter int CNT_W      = 8,
  parameter int INIT_STOCK = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_return_req,
  input  logic [BAL_W-1:0]             i_balance,
  input  logic [kNumCoins-1:0]         i_input_coin,
  input  logic                         i_refill,
  output logic [kNumCoins-1:0]         o_return_coin,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_shortfall,
  output logic [BAL_W-1:0]             o_remaining,
  output logic [kNumCoins*CNT_W-1:0]   o_stock
);

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [BAL_W-1:0]       remaining_q, remaining_d;
  logic [kNumCoins-1:0]   return_coin_q, return_coin_d;
  logic [CNT_W-1:0]       stock_q [kNumCoins];
  logic [CNT_W-1:0]       stock_d [kNumCoins];

  logic [kNumCoins-1:0]   eligible;
  logic [kNumCoins-1:0]   pick;
  logic [kNumCoins-1:0]   dispense;
  logic [BAL_W-1:0]       pick_value;
  logic                   refill_now;

  function automatic logic [BAL_W-1:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = BAL_W'(100);
      1:       coin_value = BAL_W'(500);
      default: coin_value = BAL_W'(1000);
    endcase
  endfunction

  for (genvar gi = 0; gi < kNumCoins; gi++) begin : g_coin
    assign eligible[gi] = (stock_q[gi] != '0) && (remaining_q >= coin_value(gi));
    assign o_stock[gi*CNT_W +: CNT_W] = stock_q[gi];
  end

  // Ascending scan so the largest eligible denomination overrides smaller ones.
  always_comb begin
    pick       = '0;
    pick_value = '0;
    for (int d = 0; d < kNumCoins; d++) begin
      if (eligible[d]) begin
        pick       = '0;
        pick[d]    = 1'b1;
        pick_value = coin_value(d);
      end
    end
  end

  assign dispense   = (state_q == S_DISPENSE) ? pick : '0;
  assign refill_now = (state_q == S_IDLE) && i_refill && !i_return_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (i_return_req) state_d = S_DISPENSE;
      S_DISPENSE: if (pick == '0)   state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_done      = (state_q == S_DONE);
    o_shortfall = (state_q == S_DONE) && (remaining_q != '0);
  end

  assign o_return_coin = return_coin_q;
  assign o_remaining   = remaining_q;

  always_comb begin
    remaining_d   = remaining_q;
    return_coin_d = '0;
    if (state_q == S_IDLE && i_return_req) begin
      remaining_d = i_balance;
    end else if (state_q == S_DISPENSE && pick != '0) begin
      return_coin_d = pick;
      remaining_d   = remaining_q - pick_value;
    end
  end

  // Insert and dispense of the same coin cancel; a full counter drops insertions.
  always_comb begin
    for (int i = 0; i < kNumCoins; i++) begin
      stock_d[i] = stock_q[i];
      if (refill_now) begin
        stock_d[i] = CNT_W'(INIT_STOCK);
      end else if (i_input_coin[i] && !dispense[i]) begin
        if (stock_q[i] != '1) stock_d[i] = stock_q[i] + 1'b1;
      end else if (dispense[i] && !i_input_coin[i]) begin
        stock_d[i] = stock_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q   <= '0;
      return_coin_q <= '0;
      for (int i = 0; i < kNumCoins; i++) stock_q[i] <= CNT_W'(INIT_STOCK);
    end else begin
      remaining_q   <= remaining_d;
      return_coin_q <= return_coin_d;
      for (int i = 0; i < kNumCoins; i++) stock_q[i] <= stock_d[i];
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: constant vector table, hand-written corner
// sequences, and randomized transactions against an arithmetic greedy-payout model.
module tb_change_dispenser;

  localparam int BAL_W = 32;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_return_req;
  logic [BAL_W-1:0]  i_balance;
  logic [2:0]        i_input_coin;
  logic              i_refill;
  logic [2:0]        o_return_coin;
  logic              o_busy, o_done, o_shortfall;
  logic [BAL_W-1:0]  o_remaining;
  logic [3*CNT_W-1:0] o_stock;

  always #5 clk = ~clk;

  change_dispenser #(.kNumCoins(3), .BAL_W(BAL_W), .CNT_W(CNT_W), .INIT_STOCK(8)) dut (
    .clk(clk), .reset_n(reset_n), .i_return_req(i_return_req), .i_balance(i_balance),
    .i_input_coin(i_input_coin), .i_refill(i_refill), .o_return_coin(o_return_coin),
    .o_busy(o_busy), .o_done(o_done), .o_shortfall(o_shortfall),
    .o_remaining(o_remaining), .o_stock(o_stock)
  );

  int          checks = 0;
  int          failures = 0;
  int          m_stock [3];
  logic [2:0]  exp_q [$];
  logic [2:0]  got_q [$];
  longint      exp_rem;
  longint      got_rem;
  logic        got_short;

  typedef struct {
    int     bal;
    int     n1000, n500, n100;
    int     rem;
    logic   sh;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_packed();
    return (longint'(m_stock[2]) << 16) | (longint'(m_stock[1]) << 8) | longint'(m_stock[0]);
  endfunction

  function automatic int coin_val(input int d);
    return (d == 2) ? 1000 : (d == 1) ? 500 : 100;
  endfunction

  // Greedy payout as plain arithmetic: as many of each coin as fit, largest first.
  task automatic model_pay(input int bal);
    int rem = bal;
    exp_q.delete();
    for (int d = 2; d >= 0; d--) begin
      int n = rem / coin_val(d);
      if (n > m_stock[d]) n = m_stock[d];
      for (int k = 0; k < n; k++) exp_q.push_back(3'(1 << d));
      rem -= n * coin_val(d);
      m_stock[d] -= n;
    end
    exp_rem = rem;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; i_return_req = 1'b0; i_balance = '0; i_input_coin = '0; i_refill = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) m_stock[d] = 8;
  endtask

  task automatic idle_cycle(input logic [2:0] coin, input logic refill);
    i_input_coin = coin; i_refill = refill;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (refill) m_stock[d] = 8;
      else if (coin[d] && m_stock[d] < 255) m_stock[d]++;
    end
    i_input_coin = '0; i_refill = 1'b0;
  endtask

  task automatic run_pay(input int bal, input logic refill_too, input logic busy_req,
                         input logic [2:0] ins_e1, input logic refill_e1, input string tag);
    logic done_seen = 1'b0;
    got_q.delete();
    i_return_req = 1'b1; i_balance = BAL_W'(bal); i_refill = refill_too;
    @(negedge clk);
    i_return_req = busy_req; i_balance = busy_req ? BAL_W'(500) : BAL_W'(bal);
    i_refill = refill_e1; i_input_coin = ins_e1;
    check({tag, "_busy_after_e0"}, o_busy, 1);
    check({tag, "_remaining_after_e0"}, o_remaining, bal);
    @(negedge clk);
    i_return_req = 1'b0; i_refill = 1'b0; i_input_coin = '0;
    for (int c = 0; c < 40; c++) begin
      if (o_done) begin done_seen = 1'b1; break; end
      got_q.push_back(o_return_coin);
      @(negedge clk);
    end
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_coin_at_done"}, o_return_coin, 0);
    got_rem = o_remaining; got_short = o_shortfall;
    @(negedge clk);
    check({tag, "_idle_after_done"}, {o_busy, o_done}, 0);
  endtask

  task automatic compare_pay(input string tag);
    int bad = -1;
    check({tag, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin bad = i; break; end
    check({tag, "_coin_seq_first_bad"}, bad, -1);
    check({tag, "_remaining"}, got_rem, exp_rem);
    check({tag, "_shortfall"}, got_short, (exp_rem != 0) ? 1 : 0);
    check({tag, "_stock"}, o_stock, model_packed());
  endtask

  initial begin
    vecs[0] = '{1600, 1, 1, 1, 0, 1'b0};
    vecs[1] = '{350, 0, 0, 3, 50, 1'b1};
    vecs[2] = '{0, 0, 0, 0, 0, 1'b0};
    vecs[3] = '{50, 0, 0, 0, 50, 1'b1};
    vecs[4] = '{12800, 8, 8, 8, 0, 1'b0};
    vecs[5] = '{20000, 8, 8, 8, 7200, 1'b1};
    vecs[6] = '{1100, 1, 0, 1, 0, 1'b0};
    vecs[7] = '{900, 0, 1, 4, 0, 1'b0};

    // Reset state, checked both during and after reset.
    reset_n = 1'b0; i_return_req = 1'b0; i_balance = '0; i_input_coin = '0; i_refill = 1'b0;
    #12;
    check("reset_outputs", {o_return_coin, o_busy, o_done, o_shortfall}, 0);
    check("reset_remaining", o_remaining, 0);
    check("reset_stock", o_stock, 24'h080808);
    do_reset();
    check("post_reset_idle", {o_busy, o_done, o_return_coin}, 0);

    // Constant vector table, each from full stock.
    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d_bal%0d", v, vecs[v].bal);
      do_reset();
      exp_q.delete();
      for (int k = 0; k < vecs[v].n1000; k++) exp_q.push_back(3'b100);
      for (int k = 0; k < vecs[v].n500;  k++) exp_q.push_back(3'b010);
      for (int k = 0; k < vecs[v].n100;  k++) exp_q.push_back(3'b001);
      exp_rem = vecs[v].rem;
      m_stock[2] = 8 - vecs[v].n1000; m_stock[1] = 8 - vecs[v].n500; m_stock[0] = 8 - vecs[v].n100;
      run_pay(vecs[v].bal, 1'b0, 1'b0, 3'b000, 1'b0, tag);
      compare_pay(tag);
      check({tag, "_shortfall_const"}, got_short, vecs[v].sh);
    end

    // 1000 stock drained, then 1200 falls back to 500s and 100s.
    do_reset();
    model_pay(8000); run_pay(8000, 1'b0, 1'b0, 3'b000, 1'b0, "drain1000"); compare_pay("drain1000");
    model_pay(1200); run_pay(1200, 1'b0, 1'b0, 3'b000, 1'b0, "empty1000"); compare_pay("empty1000");
    check("empty1000_ncoins_const", got_q.size(), 4);
    check("empty1000_stock_const", o_stock, 24'h000606);

    // Insertion of a 500 on the cycle a 500 is paid leaves the stock unchanged.
    do_reset();
    model_pay(500);
    for (int d = 0; d < 3; d++) if (d == 1 && m_stock[d] < 255) m_stock[d]++;
    run_pay(500, 1'b0, 1'b0, 3'b010, 1'b0, "ins_same");
    compare_pay("ins_same");
    check("ins_same_stock500", o_stock[15:8], 8);

    // Refill while dispensing is ignored.
    do_reset();
    model_pay(1600); run_pay(1600, 1'b0, 1'b0, 3'b000, 1'b1, "refill_busy"); compare_pay("refill_busy");
    check("refill_busy_stock_const", o_stock, 24'h070707);

    // Saturation of a stock counter at 255.
    do_reset();
    for (int k = 0; k < 247; k++) idle_cycle(3'b001, 1'b0);
    check("sat_reach255", o_stock[7:0], 255);
    idle_cycle(3'b001, 1'b0);
    check("sat_drop", o_stock[7:0], 255);
    idle_cycle(3'b001, 1'b1);
    check("refill_beats_insert", o_stock, 24'h080808);

    // Asynchronous reset in the middle of a payout.
    do_reset();
    i_return_req = 1'b1; i_balance = 1600;
    @(negedge clk);
    i_return_req = 1'b0;
    @(negedge clk);
    check("midreset_first_coin", o_return_coin, 3'b100);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {o_return_coin, o_busy, o_done, o_shortfall}, 0);
    check("midreset_remaining", o_remaining, 0);
    check("midreset_stock", o_stock, 24'h080808);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midreset_idle", o_busy, 0);
    for (int d = 0; d < 3; d++) m_stock[d] = 8;

    // Request and refill together: request wins; request while busy is ignored.
    model_pay(1600); run_pay(1600, 1'b0, 1'b0, 3'b000, 1'b0, "prec_pre"); compare_pay("prec_pre");
    model_pay(100);  run_pay(100, 1'b1, 1'b0, 3'b000, 1'b0, "req_refill"); compare_pay("req_refill");
    check("req_refill_stock_const", o_stock, 24'h070706);
    model_pay(1100); run_pay(1100, 1'b0, 1'b1, 3'b000, 1'b0, "busy_req"); compare_pay("busy_req");
    repeat (2) @(negedge clk);
    check("busy_req_no_restart", o_busy, 0);

    // Randomized transactions against the model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      int n_idle = $urandom_range(0, 3);
      int bal = $urandom_range(0, 60) * 50;
      string tag;
      for (int k = 0; k < n_idle; k++) begin
        int c = $urandom_range(0, 3);
        idle_cycle((c == 0) ? 3'b000 : 3'(1 << (c - 1)), ($urandom_range(0, 15) == 0));
      end
      tag = $sformatf("rnd%0d_bal%0d", t, bal);
      model_pay(bal);
      run_pay(bal, 1'b0, 1'b0, 3'b000, 1'b0, tag);
      compare_pay(tag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
